s298_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for one s298 core (the circuit under test, CUT).
- Drives the CUT's three primary inputs (G0, G1, G2) from a 16-bit LFSR for a programmed number of patterns.
- Compacts the CUT's six primary outputs into a 16-bit MISR and compares the final signature with a golden value.
- Sits beside the s298 instance in the benchmark harness; the start/busy/done handshake goes to the test master.

---
 rtl/s298_bist_ctrl.sv | 126 ++++++++++++
 tb/tb_s298_bist_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s298_bist_ctrl.sv
// BIST sequencer for one s298 core: LFSR pattern source on G0..G2,
// 16-bit MISR compaction of the six CUT outputs, golden-signature compare.
module s298_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter int unsigned INIT_CYCLES  = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] GOLDEN,
  output logic        CUT_G0,
  output logic        CUT_G1,
  output logic        CUT_G2,
  input  logic [5:0]  CUT_RESP,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIG,
  output logic [15:0] PAT_CNT
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] NPAT      = 16'(NUM_PATTERNS);
  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] pat_q, pat_d;
  logic [3:0]  init_q, init_d;
  logic        pass_q, pass_d;

  logic [15:0] lfsr_nxt;
  logic [15:0] misr_nxt;
  logic [15:0] pat_inc;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      misr_q  <= '0;
      pat_q   <= '0;
      init_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      pat_q   <= pat_d;
      init_q  <= init_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    pat_d    = pat_q;
    init_d   = init_q;
    pass_d   = pass_q;
    lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    misr_nxt = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
               ^ {10'b0, CUT_RESP};
    pat_inc  = pat_q + 16'd1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_INIT;
          lfsr_d  = SEED_EFF;
          misr_d  = '0;
          pat_d   = '0;
          init_d  = '0;
          pass_d  = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (init_q == INIT_LAST) state_d = S_RUN;
        else                     init_d  = init_q + 4'd1;
      end
      S_RUN: begin
        pat_d  = pat_inc;
        lfsr_d = lfsr_nxt;
        // CUT outputs are registered: the response to pattern k arrives one
        // cycle later, so the first RUN edge has nothing to absorb yet.
        if (pat_q != 16'd0) misr_d = misr_nxt;
        if (pat_inc == NPAT) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        misr_d  = misr_nxt;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        pass_d  = (misr_q == GOLDEN);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    {CUT_G2, CUT_G1, CUT_G0} = (state_q == S_RUN) ? lfsr_q[2:0] : 3'b001;
    BUSY = (state_q == S_INIT) || (state_q == S_RUN) ||
           (state_q == S_FLUSH) || (state_q == S_CHECK);
    DONE = (state_q == S_DONE);
  end

  assign PASS    = pass_q;
  assign SIG     = misr_q;
  assign PAT_CNT = pat_q;

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Bench for s298_bist_ctrl: a main 256-pattern instance against a registered
// CUT stand-in (scoreboarded), plus small instances for timing and
// forced-response signature checks.
module tb_s298_bist_ctrl;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  // Main instance signals
  logic        start_m;
  logic [15:0] golden_m;
  logic [5:0]  resp_m;
  logic        g0_m, g1_m, g2_m, busy_m, done_m, pass_m;
  logic [15:0] sig_m, pcnt_m;

  // Small instances share START/GOLDEN
  logic        start_s;
  logic [15:0] gold_s = 16'h0041;
  logic [5:0]  resp_4 = 6'h15;
  logic [5:0]  resp_2 = 6'h3F;
  logic [5:0]  resp_1 = 6'h00;
  logic        g0_4, g1_4, g2_4, busy_4, done_4, pass_4;
  logic        g0_2, g1_2, g2_2, busy_2, done_2, pass_2;
  logic        g0_1, g1_1, g2_1, busy_1, done_1, pass_1;
  logic [15:0] sig_4, pcnt_4, sig_2, pcnt_2, sig_1, pcnt_1;

  s298_bist_ctrl #(.NUM_PATTERNS(256), .INIT_CYCLES(2), .LFSR_SEED(16'hACE1)) u_main (
    .CK(CK), .RST(RST), .START(start_m), .GOLDEN(golden_m),
    .CUT_G0(g0_m), .CUT_G1(g1_m), .CUT_G2(g2_m), .CUT_RESP(resp_m),
    .BUSY(busy_m), .DONE(done_m), .PASS(pass_m), .SIG(sig_m), .PAT_CNT(pcnt_m));

  s298_bist_ctrl #(.NUM_PATTERNS(4), .INIT_CYCLES(2), .LFSR_SEED(16'hACE1)) u_t4 (
    .CK(CK), .RST(RST), .START(start_s), .GOLDEN(gold_s),
    .CUT_G0(g0_4), .CUT_G1(g1_4), .CUT_G2(g2_4), .CUT_RESP(resp_4),
    .BUSY(busy_4), .DONE(done_4), .PASS(pass_4), .SIG(sig_4), .PAT_CNT(pcnt_4));

  s298_bist_ctrl #(.NUM_PATTERNS(2), .INIT_CYCLES(1), .LFSR_SEED(16'hACE1)) u_t2 (
    .CK(CK), .RST(RST), .START(start_s), .GOLDEN(gold_s),
    .CUT_G0(g0_2), .CUT_G1(g1_2), .CUT_G2(g2_2), .CUT_RESP(resp_2),
    .BUSY(busy_2), .DONE(done_2), .PASS(pass_2), .SIG(sig_2), .PAT_CNT(pcnt_2));

  s298_bist_ctrl #(.NUM_PATTERNS(1), .INIT_CYCLES(1), .LFSR_SEED(16'hACE1)) u_t1 (
    .CK(CK), .RST(RST), .START(start_s), .GOLDEN(gold_s),
    .CUT_G0(g0_1), .CUT_G1(g1_1), .CUT_G2(g2_1), .CUT_RESP(resp_1),
    .BUSY(busy_1), .DONE(done_1), .PASS(pass_1), .SIG(sig_1), .PAT_CNT(pcnt_1));

  // Registered CUT stand-in: outputs are a lookup of the previous input vector.
  logic [5:0] cut_tab [8];
  logic [5:0] cut_q;
  always @(posedge CK) cut_q <= cut_tab[{g2_m, g1_m, g0_m}];
  assign resp_m = cut_q;

  // Reference: walk the pattern sequence and fold each response into the signature.
  function automatic logic [15:0] model_sig(input int unsigned n);
    logic [15:0] l;
    logic [15:0] m;
    l = 16'hACE1;
    m = '0;
    for (int unsigned i = 0; i < n; i++) begin
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, cut_tab[l[2:0]]};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return m;
  endfunction

  typedef struct {
    logic        pass;
    logic [15:0] sig;
    logic [15:0] pcnt;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each rising DONE on the main instance consumes one expectation.
  always @(negedge CK) begin
    if (done_m === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got DONE expected none queued");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_sig", 32'(sig_m), 32'(mon_e.sig));
        chk("sb_pass", 32'(pass_m), 32'(mon_e.pass));
        chk("sb_pat_cnt", 32'(pcnt_m), 32'(mon_e.pcnt));
      end
    end
    done_prev = done_m;
  end

  task automatic rand_tab();
    for (int i = 0; i < 8; i++) cut_tab[i] = 6'($urandom);
  endtask

  task automatic wait_pcnt(input logic [15:0] v);
    int n = 0;
    while (pcnt_m < v && n < 2000) begin
      @(negedge CK);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_pcnt_timeout: got %h expected %h", pcnt_m, v);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_m !== 1'b1 && n < 2000) begin
      @(negedge CK);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got DONE=%b expected 1", done_m);
    end
  endtask

  // One main run: junk GOLDEN early, the real one loaded late in RUN.
  task automatic run_main(input bit good, input bit pulse_mid);
    logic [15:0] s, g, p0;
    exp_t e;
    rand_tab();
    s = model_sig(256);
    g = good ? s : (s ^ 16'h0001);
    e.pass = good;
    e.sig  = s;
    e.pcnt = 16'd256;
    sb.push_back(e);
    golden_m = 16'($urandom);
    start_m = 1'b1;
    @(negedge CK);
    start_m = 1'b0;
    wait_pcnt(16'd50);
    if (pulse_mid) begin
      p0 = pcnt_m;
      start_m = 1'b1;
      @(negedge CK);
      start_m = 1'b0;
      chk("mid_start_busy", 32'(busy_m), 32'd1);
      chk("mid_start_pcnt", 32'(pcnt_m), 32'(p0) + 32'd1);
    end
    wait_pcnt(16'd200);
    golden_m = g;
    wait_done();
    @(negedge CK);
    golden_m = ~g;
    chk("idle_done", 32'(done_m), 32'd0);
    chk("idle_pass_kept", 32'(pass_m), 32'(good));
    chk("idle_sig_kept", 32'(sig_m), 32'(s));
  endtask

  logic [2:0] exp_g [4] = '{3'b001, 3'b011, 3'b111, 3'b111};

  initial begin
    logic [15:0] s;
    exp_t e;
    int n;
    RST = 1'b1;
    start_m = 1'b1;
    start_s = 1'b1;
    golden_m = '0;
    rand_tab();

    // Reset held two cycles with START high
    for (int c = 0; c < 2; c++) begin
      @(negedge CK);
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
      chk("rst_pass", 32'(pass_m), 32'd0);
      chk("rst_sig", 32'(sig_m), 32'd0);
      chk("rst_pcnt", 32'(pcnt_m), 32'd0);
      chk("rst_cut_g", 32'({g2_m, g1_m, g0_m}), 32'd1);
    end
    RST = 1'b0;
    start_m = 1'b0;
    start_s = 1'b0;
    @(negedge CK);

    // Cycle-exact timing on the 4-pattern instance
    start_s = 1'b1;
    @(negedge CK);
    start_s = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("t4_busy_c%0d", k), 32'(busy_4), 32'(k <= 8));
      chk($sformatf("t4_done_c%0d", k), 32'(done_4), 32'(k == 9));
      chk($sformatf("t4_cut_g_c%0d", k), 32'({g2_4, g1_4, g0_4}),
          (k >= 3 && k <= 6) ? 32'(exp_g[k-3]) : 32'd1);
      if (k == 9) chk("t4_pcnt", 32'(pcnt_4), 32'd4);
      if (k < 9) @(negedge CK);
    end
    chk("t2_sig", 32'(sig_2), 32'h0041);
    chk("t2_pass", 32'(pass_2), 32'd1);
    chk("t1_sig", 32'(sig_1), 32'h0000);
    chk("t1_pass", 32'(pass_1), 32'd0);

    // Randomized scoreboarded runs
    for (int r = 0; r < 4; r++) begin
      run_main(bit'($urandom_range(0, 1)), bit'(r[0]));
      @(negedge CK);
    end
    run_main(1'b0, 1'b0);
    @(negedge CK);

    // Reset mid-run at PAT_CNT=100, then a clean run with the same CUT
    start_m = 1'b1;
    @(negedge CK);
    start_m = 1'b0;
    wait_pcnt(16'd100);
    chk("abort_at_pcnt", 32'(pcnt_m), 32'd100);
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_sig", 32'(sig_m), 32'd0);
    chk("abort_pcnt", 32'(pcnt_m), 32'd0);
    chk("abort_done", 32'(done_m), 32'd0);
    run_main(1'b1, 1'b0);
    @(negedge CK);

    // Back-to-back: START held through DONE
    rand_tab();
    s = model_sig(256);
    golden_m = s;
    e.pass = 1'b1;
    e.sig  = s;
    e.pcnt = 16'd256;
    sb.push_back(e);
    sb.push_back(e);
    start_m = 1'b1;
    @(negedge CK);
    wait_done();
    @(negedge CK);
    start_m = 1'b0;
    chk("b2b_rearm_busy", 32'(busy_m), 32'd1);
    chk("b2b_rearm_done", 32'(done_m), 32'd0);
    chk("b2b_rearm_pass", 32'(pass_m), 32'd0);
    n = 1;
    while (done_m !== 1'b1 && n < 2000) begin
      @(negedge CK);
      n++;
    end
    chk("b2b_cycles_to_done", 32'(n), 32'd261);
    @(negedge CK);
    @(negedge CK);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
